// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter transmitter: letter codes, FSM states
// and the MSB-first on/off patterns for each letter.
package morse_pkg;

  localparam int MORSE_PAT_W = 14;

  localparam logic [2:0] LETTER_S = 3'd0;
  localparam logic [2:0] LETTER_T = 3'd1;
  localparam logic [2:0] LETTER_U = 3'd2;
  localparam logic [2:0] LETTER_V = 3'd3;
  localparam logic [2:0] LETTER_W = 3'd4;
  localparam logic [2:0] LETTER_X = 3'd5;
  localparam logic [2:0] LETTER_Y = 3'd6;
  localparam logic [2:0] LETTER_Z = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Element [k] holds the pattern for letter code k (Z is listed first).
  localparam logic [7:0][MORSE_PAT_W-1:0] MORSE_PATTERNS = {
    14'b11101110101000,  // Z
    14'b11101011101110,  // Y
    14'b11101010111000,  // X
    14'b10111011100000,  // W
    14'b10101011100000,  // V
    14'b10101110000000,  // U
    14'b11100000000000,  // T
    14'b10101000000000   // S
  };

  function automatic logic [MORSE_PAT_W-1:0] pattern_of(input logic [2:0] code);
    return MORSE_PATTERNS[code];
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Symbol-rate down-counter: tick is high on the last cycle of each symbol period.
module morse_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] RELOAD_VAL = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || reload) begin
      count <= RELOAD_VAL;
    end else if (count == '0) begin
      count <= RELOAD_VAL;
    end else begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/morse_tx_controller.sv
// Sends one Morse letter at a time on led, followed by a fixed dark gap, with a
// one-deep buffer so a second letter can be queued while the first is sent.
module morse_tx_controller
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int GAP_TICKS = 3,
  parameter int PAT_W     = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] letter,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       led,
  output logic       done
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  state_t           state;
  state_t           next_state;
  logic [PAT_W-1:0] shreg;
  logic [PAT_W-1:0] shifted;
  logic [GW-1:0]    gap_cnt;
  logic             pend_valid;
  logic [2:0]       pend_letter;
  logic             done_q;
  logic             tick;
  logic             accept;
  logic             gap_end;

  assign accept  = start && !pend_valid && !abort;
  assign shifted = shreg << 1;
  assign gap_end = (state == GAP) && tick && (gap_cnt == '0);

  // Counter is held at its reload value whenever no letter is in flight.
  morse_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .reload(abort || (state == IDLE)),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) next_state = SEND;
        SEND: if (tick && (shifted == '0)) next_state = GAP;
        GAP: begin
          if (gap_end) begin
            next_state = (pend_valid || accept) ? SEND : IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Pattern shifting, gap counting, pending buffer and the completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg       <= '0;
      gap_cnt     <= '0;
      pend_valid  <= 1'b0;
      pend_letter <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        shreg      <= '0;
        gap_cnt    <= '0;
        pend_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) shreg <= PAT_W'(pattern_of(letter));
          end
          SEND: begin
            if (tick) begin
              shreg <= shifted;
              if (shifted == '0) gap_cnt <= GW'(GAP_TICKS - 1);
            end
            if (accept) begin
              pend_valid  <= 1'b1;
              pend_letter <= letter;
            end
          end
          GAP: begin
            if (gap_end) begin
              if (pend_valid) begin
                shreg      <= PAT_W'(pattern_of(pend_letter));
                pend_valid <= 1'b0;
              end else if (accept) begin
                shreg <= PAT_W'(pattern_of(letter));
              end else begin
                done_q <= 1'b1;
              end
            end else begin
              if (tick) gap_cnt <= gap_cnt - GW'(1);
              if (accept) begin
                pend_valid  <= 1'b1;
                pend_letter <= letter;
              end
            end
          end
          default: shreg <= '0;
        endcase
      end
    end
  end

  always_comb begin
    busy  = (state == SEND) || (state == GAP);
    led   = (state == SEND) && shreg[PAT_W-1];
    ready = !pend_valid;
    done  = done_q;
  end

endmodule

// File: tb/tb_morse_tx_controller.sv
// Cycle-by-cycle check of morse_tx_controller against traces built from the
// dot/dash spelling of each letter.
module tb_morse_tx_controller;

  localparam int TD   = 4;
  localparam int GT   = 3;
  localparam int MAXC = 128;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] letter;
  logic       abort;
  logic       ready;
  logic       busy;
  logic       led;
  logic       done;

  always #5 clock = ~clock;

  morse_tx_controller #(
    .TICK_DIV (TD),
    .GAP_TICKS(GT),
    .PAT_W    (14)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .letter(letter),
    .abort (abort),
    .ready (ready),
    .busy  (busy),
    .led   (led),
    .done  (done)
  );

  typedef struct {
    logic [3:0] outs;
    int         cycle;
  } exp_t;

  typedef struct {
    logic [2:0] code;
    int         done_cycle;
  } vec_t;

  exp_t  sb[$];
  int    checks = 0;
  int    passed = 0;
  string morse_code[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

  logic       plan_start[MAXC];
  logic       plan_abort[MAXC];
  logic       plan_reset[MAXC];
  logic [2:0] plan_letter[MAXC];
  logic       exp_led[MAXC];
  logic       exp_busy[MAXC];
  logic       exp_ready[MAXC];
  logic       exp_done[MAXC];

  task automatic clear_plan();
    for (int c = 0; c < MAXC; c++) begin
      plan_start[c]  = 1'b0;
      plan_abort[c]  = 1'b0;
      plan_reset[c]  = 1'b0;
      plan_letter[c] = 3'($urandom_range(0, 7));
      exp_led[c]     = 1'b0;
      exp_busy[c]    = 1'b0;
      exp_ready[c]   = 1'b1;
      exp_done[c]    = 1'b0;
    end
  endtask

  task automatic truncate_from(input int c0);
    for (int c = c0; c < MAXC; c++) begin
      exp_led[c]   = 1'b0;
      exp_busy[c]  = 1'b0;
      exp_ready[c] = 1'b1;
      exp_done[c]  = 1'b0;
    end
  endtask

  // Dot = 1 symbol lit, dash = 3, one dark symbol between elements, then the gap.
  task automatic add_letter(input logic [2:0] code, input int first, output int idle_cycle);
    string m;
    int    c;
    int    n;
    m = morse_code[code];
    c = first;
    for (int i = 0; i < m.len(); i++) begin
      n = (m.getc(i) == "-") ? 3 : 1;
      for (int k = 0; k < n * TD; k++) begin
        exp_led[c]  = 1'b1;
        exp_busy[c] = 1'b1;
        c++;
      end
      if (i < m.len() - 1) begin
        for (int k = 0; k < TD; k++) begin
          exp_busy[c] = 1'b1;
          c++;
        end
      end
    end
    for (int k = 0; k < GT * TD; k++) begin
      exp_busy[c] = 1'b1;
      c++;
    end
    idle_cycle = c;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] l, input logic a, input logic r);
    start  = s;
    letter = l;
    abort  = a;
    reset  = r;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, got led/busy/ready/done=%b", tag,
               {led, busy, ready, done});
      return;
    end
    e = sb.pop_front();
    if ({led, busy, ready, done} === e.outs) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s cycle %0d: led/busy/ready/done got %b expected %b", tag, e.cycle,
               {led, busy, ready, done}, e.outs);
    end
  endtask

  task automatic run_plan(input int ncycles, input string tag);
    exp_t e;
    for (int c = 0; c < ncycles; c++) begin
      applyStimulus(plan_start[c], plan_letter[c], plan_abort[c], plan_reset[c]);
      e.outs  = {exp_led[c], exp_busy[c], exp_ready[c], exp_done[c]};
      e.cycle = c;
      sb.push_back(e);
      checkOutput(tag);
      @(posedge clock);
      #1;
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t vecs[8];
    int   e1;
    int   e2;

    vecs[0] = '{3'd0, 33};
    vecs[1] = '{3'd1, 25};
    vecs[2] = '{3'd2, 41};
    vecs[3] = '{3'd3, 49};
    vecs[4] = '{3'd4, 49};
    vecs[5] = '{3'd5, 57};
    vecs[6] = '{3'd6, 65};
    vecs[7] = '{3'd7, 57};

    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1;

    clear_plan();
    for (int c = 0; c < 3; c++) plan_reset[c] = 1'b1;
    plan_start[1] = 1'b1;
    run_plan(5, "reset_hold");

    // Single letters; the letter input wanders randomly after the accepting cycle.
    for (int v = 0; v < 8; v++) begin
      clear_plan();
      plan_start[0]  = 1'b1;
      plan_letter[0] = vecs[v].code;
      add_letter(vecs[v].code, 1, e1);
      exp_done[vecs[v].done_cycle] = 1'b1;
      run_plan(vecs[v].done_cycle + 2, $sformatf("single_%s", morse_code[vecs[v].code]));
    end

    clear_plan();
    plan_start[0]  = 1'b1;
    plan_letter[0] = 3'd0;
    plan_start[6]  = 1'b1;
    plan_letter[6] = 3'd1;
    plan_start[10] = 1'b1;
    plan_letter[10] = 3'd7;
    add_letter(3'd0, 1, e1);
    add_letter(3'd1, e1, e2);
    for (int c = 7; c < e1; c++) exp_ready[c] = 1'b0;
    exp_done[e2] = 1'b1;
    run_plan(e2 + 2, "queued_S_T");

    clear_plan();
    plan_start[0]  = 1'b1;
    plan_letter[0] = 3'd4;
    plan_start[5]  = 1'b1;
    plan_letter[5] = 3'd3;
    plan_abort[9]  = 1'b1;
    plan_start[12] = 1'b1;
    plan_abort[12] = 1'b1;
    add_letter(3'd4, 1, e1);
    truncate_from(10);
    for (int c = 6; c < 10; c++) exp_ready[c] = 1'b0;
    run_plan(e1 + 4, "abort_W");

    clear_plan();
    plan_start[0]  = 1'b1;
    plan_letter[0] = 3'd1;
    plan_reset[15] = 1'b1;
    plan_start[16] = 1'b1;
    plan_letter[16] = 3'd1;
    add_letter(3'd1, 1, e1);
    truncate_from(16);
    add_letter(3'd1, 17, e2);
    exp_done[e2] = 1'b1;
    run_plan(e2 + 2, "reset_mid_gap");

    clear_plan();
    plan_start[0]  = 1'b1;
    plan_letter[0] = 3'd1;
    plan_start[24] = 1'b1;
    plan_letter[24] = 3'd2;
    add_letter(3'd1, 1, e1);
    add_letter(3'd2, e1, e2);
    exp_done[e2] = 1'b1;
    run_plan(e2 + 2, "back_to_back");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
